// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS phase-accumulator front end.
package dds_pkg;

   localparam int ACC_W_DEF  = 32;
   localparam int ADDR_W_DEF = 8;

   typedef enum logic [1:0] {
      WAVE_SIN = 2'd0,
      WAVE_TRI = 2'd1,
      WAVE_SQR = 2'd2,
      WAVE_SAW = 2'd3
   } wave_sel_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } dds_state_t;

   typedef struct packed {
      logic [ACC_W_DEF-1:0]  fcw;
      logic [ADDR_W_DEF-1:0] phase;
      wave_sel_t             sel;
   } dds_cfg_t;

endpackage

// File: rtl/dds_cfg_shadow.sv
// Active oscillator settings plus a shadow copy that is promoted on request,
// so a new configuration only takes effect when the controller allows it.
module dds_cfg_shadow
   import dds_pkg::*;
#(
   parameter int ACC_W  = ACC_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_active,
   input  logic              load_shadow,
   input  logic              apply,
   input  logic [ACC_W-1:0]  cfg_fcw,
   input  logic [ADDR_W-1:0] cfg_phase,
   input  logic [1:0]        cfg_sel,
   output logic [ACC_W-1:0]  active_fcw,
   output logic [ADDR_W-1:0] active_phase,
   output logic [1:0]        active_sel,
   output logic [ADDR_W-1:0] next_phase
);

   logic [ACC_W-1:0]  shadow_fcw;
   logic [ADDR_W-1:0] shadow_phase;
   logic [1:0]        shadow_sel;

   logic [ACC_W-1:0]  fcw_d;
   logic [ADDR_W-1:0] phase_d;
   logic [1:0]        sel_d;

   always_comb begin
      // NOTE: defaults first so every path assigns each output; no latch is inferred.
      fcw_d   = active_fcw;
      phase_d = active_phase;
      sel_d   = active_sel;
      if (load_active) begin
         fcw_d   = cfg_fcw;
         phase_d = cfg_phase;
         sel_d   = cfg_sel;
      end else if (apply) begin
         fcw_d   = shadow_fcw;
         phase_d = shadow_phase;
         sel_d   = shadow_sel;
      end
   end

   // Lets the address register track the phase the active set is about to hold.
   assign next_phase = phase_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_fcw   <= '0;
         active_phase <= '0;
         active_sel   <= '0;
         shadow_fcw   <= '0;
         shadow_phase <= '0;
         shadow_sel   <= '0;
      end else begin
         active_fcw   <= fcw_d;
         active_phase <= phase_d;
         active_sel   <= sel_d;
         if (load_shadow) begin
            shadow_fcw   <= cfg_fcw;
            shadow_phase <= cfg_phase;
            shadow_sel   <= cfg_sel;
         end
      end
   end

endmodule

// File: rtl/dds_phase_accum.sv
// DDS phase accumulator: produces the waveform ROM address and select, and
// swaps in new settings only at a phase wrap so each period stays intact.
module dds_phase_accum
   import dds_pkg::*;
#(
   parameter int ACC_W  = ACC_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic              tick,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [ACC_W-1:0]  cfg_fcw,
   input  logic [ADDR_W-1:0] cfg_phase,
   input  logic [1:0]        cfg_sel,
   output logic [ADDR_W-1:0] address,
   output logic [1:0]        sel,
   output logic              phase_wrap
);

   dds_state_t        state, state_next;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W:0]    acc_sum;
   logic              carry;
   logic              xfer;
   logic              load_active, load_shadow, apply;
   logic              step, clear;
   logic [ACC_W-1:0]  active_fcw;
   logic [ADDR_W-1:0] active_phase;
   logic [1:0]        active_sel;
   logic [ADDR_W-1:0] next_phase;

   dds_cfg_shadow #(
      .ACC_W  (ACC_W),
      .ADDR_W (ADDR_W)
   ) u_cfg (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_active  (load_active),
      .load_shadow  (load_shadow),
      .apply        (apply),
      .cfg_fcw      (cfg_fcw),
      .cfg_phase    (cfg_phase),
      .cfg_sel      (cfg_sel),
      .active_fcw   (active_fcw),
      .active_phase (active_phase),
      .active_sel   (active_sel),
      .next_phase   (next_phase)
   );

   assign cfg_ready = (state != ST_PEND);
   assign xfer      = cfg_valid & cfg_ready;
   assign acc_sum   = {1'b0, acc} + {1'b0, active_fcw};
   assign carry     = acc_sum[ACC_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next  = state;
      load_active = 1'b0;
      load_shadow = 1'b0;
      apply       = 1'b0;
      step        = 1'b0;
      clear       = 1'b0;
      unique case (state)
         ST_IDLE: begin
            clear       = 1'b1;
            load_active = xfer;
            if (run) state_next = ST_RUN;
         end
         ST_RUN: begin
            if (!run) begin
               clear       = 1'b1;
               load_active = xfer;
               state_next  = ST_IDLE;
            end else begin
               step = tick;
               if (xfer) begin
                  load_shadow = 1'b1;
                  state_next  = ST_PEND;
               end
            end
         end
         ST_PEND: begin
            if (!run) begin
               clear      = 1'b1;
               apply      = 1'b1;
               state_next = ST_IDLE;
            end else begin
               step = tick;
               // A zero FCW never wraps, so the shadow would otherwise stall forever.
               if (tick && (carry || active_fcw == '0)) begin
                  apply      = 1'b1;
                  state_next = ST_RUN;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc        <= '0;
         address    <= '0;
         sel        <= '0;
         phase_wrap <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values together.
         sel <= active_sel;
         if (clear) begin
            acc        <= '0;
            address    <= next_phase;
            phase_wrap <= 1'b0;
         end else if (step) begin
            acc        <= acc_sum[ACC_W-1:0];
            address    <= acc_sum[ACC_W-1 -: ADDR_W] + active_phase;
            phase_wrap <= carry;
         end else begin
            phase_wrap <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dds_phase_accum.sv
// Bench for dds_phase_accum: directed scenarios plus randomized traffic,
// every cycle scored against an arithmetic model of the oscillator.
module tb_dds_phase_accum;
   import dds_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b0;
   logic        tick = 1'b0;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [31:0] cfg_fcw = '0;
   logic [7:0]  cfg_phase = '0;
   logic [1:0]  cfg_sel = '0;
   logic [7:0]  address;
   logic [1:0]  sel;
   logic        phase_wrap;

   int n_checks = 0;
   int n_pass   = 0;

   // Model: oscillator running flag, pending flag, settings, 64-bit phase.
   bit              m_running, m_pend;
   dds_cfg_t        m_act, m_shadow;
   longint unsigned m_acc;
   logic [7:0]      exp_addr;
   logic [1:0]      exp_sel;
   logic            exp_wrap;

   localparam dds_cfg_t NOCFG = '0;

   dds_phase_accum dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (run),
      .tick       (tick),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_fcw    (cfg_fcw),
      .cfg_phase  (cfg_phase),
      .cfg_sel    (cfg_sel),
      .address    (address),
      .sel        (sel),
      .phase_wrap (phase_wrap)
   );

   always #5 clk = ~clk;

   function automatic dds_cfg_t mk(input logic [31:0] f, input logic [7:0] p, input wave_sel_t s);
      dds_cfg_t c;
      c.fcw = f; c.phase = p; c.sel = s;
      return c;
   endfunction

   task automatic model_reset();
      m_running = 0; m_pend = 0; m_act = '0; m_shadow = '0; m_acc = 0;
      exp_addr = '0; exp_sel = '0; exp_wrap = 1'b0;
   endtask

   // One clock: drive inputs, advance the model, then score all outputs.
   task automatic cycle(input bit r, input bit t, input bit v, input dds_cfg_t c);
      bit              xfer;
      longint unsigned sum;
      bit              wrapped;
      run = r; tick = t; cfg_valid = v;
      cfg_fcw = c.fcw; cfg_phase = c.phase; cfg_sel = c.sel;
      xfer    = v && !m_pend;
      exp_sel = m_act.sel;
      if (!m_running || !r) begin
         if (m_running && m_pend) m_act = m_shadow;
         else if (xfer)           m_act = c;
         m_pend    = 0;
         m_running = r && !m_running ? 1 : 0;
         m_acc     = 0;
         exp_addr  = m_act.phase;
         exp_wrap  = 1'b0;
      end else begin
         if (t) begin
            sum      = m_acc + longint'(m_act.fcw);
            wrapped  = (sum >= 64'h1_0000_0000);
            m_acc    = sum % 64'h1_0000_0000;
            exp_addr = 8'((m_acc >> 24) + longint'(m_act.phase));
            exp_wrap = wrapped;
            if (m_pend && (wrapped || m_act.fcw == 0)) begin
               m_act  = m_shadow;
               m_pend = 0;
            end
         end else begin
            exp_wrap = 1'b0;
         end
         if (xfer) begin
            m_shadow = c;
            m_pend   = 1;
         end
      end
      @(posedge clk); #1;
      n_checks += 4;
      if (address !== exp_addr) $display("FAIL model_address: got %02h expected %02h at %0t", address, exp_addr, $time);
      else n_pass++;
      if (sel !== exp_sel) $display("FAIL model_sel: got %0d expected %0d at %0t", sel, exp_sel, $time);
      else n_pass++;
      if (phase_wrap !== exp_wrap) $display("FAIL model_wrap: got %0b expected %0b at %0t", phase_wrap, exp_wrap, $time);
      else n_pass++;
      if (cfg_ready !== !m_pend) $display("FAIL model_ready: got %0b expected %0b at %0t", cfg_ready, !m_pend, $time);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      #3;
      n_checks++;
      if (address !== 8'h00 || sel !== 2'd0 || phase_wrap !== 1'b0 || cfg_ready !== 1'b1)
         $display("FAIL reset_state: addr=%02h sel=%0d wrap=%0b ready=%0b expected 00/0/0/1", address, sel, phase_wrap, cfg_ready);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      cycle(0, 0, 0, NOCFG);
   endtask

   task automatic test_wrap_sweep();
      dds_cfg_t c = mk(32'h0100_0000, 8'h00, WAVE_SIN);
      cycle(0, 0, 1, c);
      cycle(1, 1, 0, NOCFG);
      for (int i = 1; i <= 256; i++) begin
         cycle(1, 1, 0, NOCFG);
         n_checks++;
         if (address !== 8'(i) || phase_wrap !== (i == 256) || sel !== 2'd0)
            $display("FAIL sweep_step%0d: addr=%02h wrap=%0b sel=%0d expected %02h/%0b/0", i, address, phase_wrap, sel, 8'(i), (i == 256));
         else n_pass++;
      end
   endtask

   task automatic test_pend_apply();
      repeat (64) cycle(1, 1, 0, NOCFG);
      cycle(1, 1, 1, mk(32'h0200_0000, 8'h00, WAVE_SIN));
      n_checks++;
      if (address !== 8'h41 || cfg_ready !== 1'b0)
         $display("FAIL pend_enter: addr=%02h ready=%0b expected 41/0", address, cfg_ready);
      else n_pass++;
      repeat (191) cycle(1, 1, 0, NOCFG);
      n_checks++;
      if (address !== 8'h00 || phase_wrap !== 1'b1 || cfg_ready !== 1'b1)
         $display("FAIL pend_wrap: addr=%02h wrap=%0b ready=%0b expected 00/1/1", address, phase_wrap, cfg_ready);
      else n_pass++;
      cycle(1, 1, 0, NOCFG);
      cycle(1, 1, 0, NOCFG);
      n_checks++;
      if (address !== 8'h04) $display("FAIL pend_new_step: addr=%02h expected 04", address);
      else n_pass++;
   endtask

   task automatic test_coincident();
      repeat (125) cycle(1, 1, 0, NOCFG);
      cycle(1, 1, 1, mk(32'h0100_0000, 8'h00, WAVE_SIN));
      n_checks++;
      if (address !== 8'h00 || phase_wrap !== 1'b1 || cfg_ready !== 1'b0)
         $display("FAIL coinc_wrap: addr=%02h wrap=%0b ready=%0b expected 00/1/0", address, phase_wrap, cfg_ready);
      else n_pass++;
      cycle(1, 1, 0, NOCFG);
      n_checks++;
      if (address !== 8'h02) $display("FAIL coinc_old_step: addr=%02h expected 02", address);
      else n_pass++;
      repeat (127) cycle(1, 1, 0, NOCFG);
      cycle(1, 1, 0, NOCFG);
      n_checks++;
      if (address !== 8'h01 || cfg_ready !== 1'b1)
         $display("FAIL coinc_new_step: addr=%02h ready=%0b expected 01/1", address, cfg_ready);
      else n_pass++;
   endtask

   task automatic test_idle_phase();
      cycle(0, 0, 0, NOCFG);
      cycle(0, 0, 1, mk(32'h0100_0000, 8'h80, WAVE_SQR));
      n_checks++;
      if (address !== 8'h80 || sel !== 2'd0)
         $display("FAIL idle_phase_addr: addr=%02h sel=%0d expected 80/0", address, sel);
      else n_pass++;
      cycle(0, 0, 0, NOCFG);
      n_checks++;
      if (sel !== 2'd2) $display("FAIL idle_sel_delay: sel=%0d expected 2", sel);
      else n_pass++;
      cycle(1, 0, 0, NOCFG);
      cycle(1, 1, 0, NOCFG);
      n_checks++;
      if (address !== 8'h81) $display("FAIL idle_first_tick: addr=%02h expected 81", address);
      else n_pass++;
   endtask

   task automatic test_fcw_zero();
      cycle(0, 0, 0, NOCFG);
      cycle(0, 0, 1, mk(32'h0, 8'h10, WAVE_TRI));
      cycle(1, 0, 0, NOCFG);
      repeat (3) cycle(1, 1, 0, NOCFG);
      cycle(1, 0, 1, mk(32'h0100_0000, 8'h10, WAVE_TRI));
      n_checks++;
      if (cfg_ready !== 1'b0) $display("FAIL zero_pend: ready=%0b expected 0", cfg_ready);
      else n_pass++;
      cycle(1, 1, 0, NOCFG);
      n_checks++;
      if (address !== 8'h10 || cfg_ready !== 1'b1 || phase_wrap !== 1'b0)
         $display("FAIL zero_apply: addr=%02h ready=%0b wrap=%0b expected 10/1/0", address, cfg_ready, phase_wrap);
      else n_pass++;
      cycle(1, 1, 0, NOCFG);
      n_checks++;
      if (address !== 8'h11) $display("FAIL zero_next_step: addr=%02h expected 11", address);
      else n_pass++;
   endtask

   task automatic test_reset_in_pend();
      cycle(1, 1, 1, mk(32'h0200_0000, 8'h33, WAVE_SAW));
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      n_checks++;
      if (address !== 8'h00 || sel !== 2'd0 || phase_wrap !== 1'b0 || cfg_ready !== 1'b1)
         $display("FAIL pend_async_reset: addr=%02h sel=%0d wrap=%0b ready=%0b expected 00/0/0/1", address, sel, phase_wrap, cfg_ready);
      else n_pass++;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1, 0, 0, NOCFG);
      repeat (4) cycle(1, 1, 0, NOCFG);
      n_checks++;
      if (address !== 8'h00 || sel !== 2'd0)
         $display("FAIL shadow_discarded: addr=%02h sel=%0d expected 00/0", address, sel);
      else n_pass++;
   endtask

   task automatic test_run_drop();
      cycle(0, 0, 0, NOCFG);
      cycle(0, 0, 1, mk(32'h0100_0000, 8'h00, WAVE_SIN));
      cycle(1, 0, 0, NOCFG);
      repeat (5) cycle(1, 1, 0, NOCFG);
      cycle(1, 1, 1, mk(32'h0300_0000, 8'h5A, WAVE_TRI));
      cycle(0, 0, 0, NOCFG);
      n_checks++;
      if (address !== 8'h5A || phase_wrap !== 1'b0 || cfg_ready !== 1'b1)
         $display("FAIL drop_addr: addr=%02h wrap=%0b ready=%0b expected 5A/0/1", address, phase_wrap, cfg_ready);
      else n_pass++;
      cycle(0, 0, 0, NOCFG);
      n_checks++;
      if (sel !== 2'd1) $display("FAIL drop_sel: sel=%0d expected 1", sel);
      else n_pass++;
   endtask

   task automatic test_random();
      dds_cfg_t c;
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 3))
            0:       c.fcw = 32'h0;
            1:       c.fcw = $urandom;
            2:       c.fcw = 32'($urandom_range(1, 255)) << 24;
            default: c.fcw = 32'($urandom_range(0, 32'h0800_0000));
         endcase
         c.phase = 8'($urandom_range(0, 255));
         c.sel   = wave_sel_t'($urandom_range(0, 3));
         cycle($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 7) == 0, c);
      end
   endtask

   initial begin
      test_reset();
      test_wrap_sweep();
      test_pend_apply();
      test_coincident();
      test_idle_phase();
      test_fcw_zero();
      test_reset_in_pend();
      test_run_drop();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
